// File: rtl/tm1638_serial_engine.sv
// Bit-level TM1638 bus master: streams the segment/LED frame over STB/CLK/DIO and reads back
// the eight keys, repeating frame after frame for as long as it is out of reset.
module tm1638_serial_engine #(
    parameter int unsigned CLK_MHZ    = 25,
    parameter int unsigned SIO_KHZ    = 1000,
    parameter int unsigned BRIGHTNESS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] seg_frame,
    input  logic [7:0]  led,
    output logic [7:0]  keys,
    output logic        keys_valid,
    output logic        frame_done,
    output logic        sio_clk,
    output logic        sio_stb,
    input  logic        sio_data_in,
    output logic        sio_data_out,
    output logic        sio_data_out_en
);

    localparam int unsigned HALF  = (CLK_MHZ * 1000) / (2 * SIO_KHZ);
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [7:0] CMD_MODE = 8'h40;
    localparam logic [7:0] CMD_ADDR = 8'hC0;
    localparam logic [7:0] CMD_DISP = 8'h88 | 8'(BRIGHTNESS & 32'd7);
    localparam logic [7:0] CMD_READ = 8'h42;

    generate
        if (HALF < 1) begin : g_half_chk
            $error("tm1638_serial_engine: serial half-period must be at least one clk cycle");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_MODE,
        S_W_DATA,
        S_W_DISP,
        S_R_CMD,
        S_TWAIT,
        S_R_KEYS,
        S_GAP
    } state_t;

    state_t           state, state_n;
    state_t           ret_state, ret_n;
    logic [DIV_W-1:0] div_cnt;
    logic             tick_c;
    logic [2:0]       bit_cnt, bit_n;
    logic [4:0]       byte_cnt, byte_n;
    logic             phase, phase_n;
    logic [1:0]       aux_cnt, aux_n;
    logic [63:0]      seg_sh, seg_sh_n;
    logic [7:0]       led_sh, led_sh_n;
    logic [7:0]       key_sh, key_sh_n;
    logic [7:0]       keys_n;
    logic             kv_n, fd_n;
    logic             sclk_n, stb_n, dout_n, oen_n;
    logic [2:0]       digit_c;
    logic [7:0]       tx_byte_c;
    logic             last_byte_c;

    // Half-period divider; every bus output moves only on tick_c.
    assign tick_c = (div_cnt == DIV_W'(HALF - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Byte being shifted out in the current write phase (data bytes alternate segment / LED).
    always_comb begin
        digit_c     = 3'((byte_cnt - 5'd1) >> 1);
        tx_byte_c   = CMD_MODE;
        last_byte_c = 1'b1;
        case (state)
            S_W_DATA: begin
                last_byte_c = (byte_cnt == 5'd16);
                if (byte_cnt == 5'd0) begin
                    tx_byte_c = CMD_ADDR;
                end else if (byte_cnt[0]) begin
                    tx_byte_c = seg_sh[{digit_c, 3'b000} +: 8];
                end else begin
                    tx_byte_c = {7'b0, led_sh[digit_c]};
                end
            end
            S_W_DISP: tx_byte_c = CMD_DISP;
            S_R_CMD:  tx_byte_c = CMD_READ;
            default:  tx_byte_c = CMD_MODE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            ret_state       <= S_IDLE;
            bit_cnt         <= '0;
            byte_cnt        <= '0;
            phase           <= 1'b0;
            aux_cnt         <= '0;
            seg_sh          <= '0;
            led_sh          <= '0;
            key_sh          <= '0;
            keys            <= '0;
            keys_valid      <= 1'b0;
            frame_done      <= 1'b0;
            sio_clk         <= 1'b1;
            sio_stb         <= 1'b1;
            sio_data_out    <= 1'b0;
            sio_data_out_en <= 1'b0;
        end else begin
            state           <= state_n;
            ret_state       <= ret_n;
            bit_cnt         <= bit_n;
            byte_cnt        <= byte_n;
            phase           <= phase_n;
            aux_cnt         <= aux_n;
            seg_sh          <= seg_sh_n;
            led_sh          <= led_sh_n;
            key_sh          <= key_sh_n;
            keys            <= keys_n;
            keys_valid      <= kv_n;
            frame_done      <= fd_n;
            sio_clk         <= sclk_n;
            sio_stb         <= stb_n;
            sio_data_out    <= dout_n;
            sio_data_out_en <= oen_n;
        end
    end

    // Frame sequencer: phase 0 = clock low + data setup, phase 1 = clock high (sample edge).
    always_comb begin
        state_n  = state;
        ret_n    = ret_state;
        bit_n    = bit_cnt;
        byte_n   = byte_cnt;
        phase_n  = phase;
        aux_n    = aux_cnt;
        seg_sh_n = seg_sh;
        led_sh_n = led_sh;
        key_sh_n = key_sh;
        keys_n   = keys;
        kv_n     = 1'b0;
        fd_n     = 1'b0;
        sclk_n   = sio_clk;
        stb_n    = sio_stb;
        dout_n   = sio_data_out;
        oen_n    = sio_data_out_en;

        if (tick_c) begin
            case (state)
                S_IDLE: begin
                    seg_sh_n = seg_frame;
                    led_sh_n = led;
                    stb_n    = 1'b0;
                    bit_n    = '0;
                    byte_n   = '0;
                    phase_n  = 1'b0;
                    state_n  = S_W_MODE;
                end
                S_W_MODE, S_W_DATA, S_W_DISP, S_R_CMD: begin
                    if (!phase) begin
                        sclk_n  = 1'b0;
                        dout_n  = tx_byte_c[bit_cnt];
                        oen_n   = 1'b1;
                        phase_n = 1'b1;
                    end else begin
                        sclk_n  = 1'b1;
                        phase_n = 1'b0;
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_n = byte_cnt + 5'd1;
                            if (last_byte_c) begin
                                byte_n  = '0;
                                aux_n   = '0;
                                state_n = S_GAP;
                                case (state)
                                    S_W_MODE: ret_n   = S_W_DATA;
                                    S_W_DATA: ret_n   = S_W_DISP;
                                    S_W_DISP: ret_n   = S_R_CMD;
                                    default:  state_n = S_TWAIT;
                                endcase
                            end
                        end
                    end
                end
                S_TWAIT: begin
                    sclk_n = 1'b1;
                    oen_n  = 1'b0;
                    if (aux_cnt == 2'd1) begin
                        aux_n   = '0;
                        bit_n   = '0;
                        byte_n  = '0;
                        phase_n = 1'b0;
                        state_n = S_R_KEYS;
                    end else begin
                        aux_n = aux_cnt + 2'd1;
                    end
                end
                S_R_KEYS: begin
                    if (!phase) begin
                        sclk_n  = 1'b0;
                        phase_n = 1'b1;
                    end else begin
                        sclk_n  = 1'b1;
                        phase_n = 1'b0;
                        bit_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd0) key_sh_n[{byte_cnt[1:0], 1'b0}] = sio_data_in;
                        if (bit_cnt == 3'd4) key_sh_n[{byte_cnt[1:0], 1'b1}] = sio_data_in;
                        if (bit_cnt == 3'd7) begin
                            byte_n = byte_cnt + 5'd1;
                            if (byte_cnt == 5'd3) begin
                                byte_n  = '0;
                                aux_n   = '0;
                                ret_n   = S_IDLE;
                                state_n = S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    // Tick 0 raises STB; STB falls again two ticks later (the IDLE tick ends a frame).
                    aux_n = aux_cnt + 2'd1;
                    if (aux_cnt == 2'd0) begin
                        stb_n = 1'b1;
                        if (ret_state == S_IDLE) begin
                            keys_n = key_sh;
                            kv_n   = 1'b1;
                        end
                    end else if (ret_state == S_IDLE) begin
                        aux_n   = '0;
                        fd_n    = 1'b1;
                        state_n = S_IDLE;
                    end else if (aux_cnt == 2'd2) begin
                        aux_n   = '0;
                        stb_n   = 1'b0;
                        bit_n   = '0;
                        byte_n  = '0;
                        phase_n = 1'b0;
                        state_n = ret_state;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

endmodule
